stopwatch_ctrl: RTL
===================

# stopwatch_ctrl

Pushbutton front end and command sequencer for the millisecond up-counter (`up_cntr`, 5 MHz clock, 5000 cycles/ms). It synchronizes and debounces three buttons (start/stop, reset, lap) and turns them into the one-cycle `on_off` command sequences the counter accepts. It also captures lap times from the counter output. The block sits between the board buttons and the counter; the counter output feeds back into it.

## Interface
- `DEBOUNCE_CYCLES`, 100000, cycles a synced button must hold a new level before it is accepted (20 ms at 5 MHz); minimum 2
- `CNT_W`, 16, width of counter value and lap register
- `clk`  in  1  system clock, 5 MHz
- `rst`  in  1  synchronous, active-high reset
- `btn_start_stop`  in  1  raw button, asynchronous, high = pressed
- `btn_reset`  in  1  raw button, asynchronous, high = pressed
- `btn_lap`  in  1  raw button, asynchronous, high = pressed
- `cnt_up_ms`  in  CNT_W  current counter value
- `on_off`  out  3  command to counter: 000 none, 001 start, 010 stop/save, 011 stop/clear
- `running`  out  1  high while the counter is counting (state RUN)
- `lap_ms`  out  CNT_W  last captured lap value
- `lap_valid`  out  1  one-cycle pulse when `lap_ms` updates

## Operation
- Each button path:
  - two-flop synchronizer.
  - Debounce counter increments each cycle the synced value differs from the debounced level. It clears on any match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, the debounced level toggles at the next edge and the counter clears.
  - Press event = debounced 0→1, one cycle wide. Releases generate no event.
- FSM states and `on_off` (Moore, decoded from state register only):
  - IDLE 000
  - START 001
  - RUN 000
  - STOP 010
  - CLR_ARM 001
  - CLR 011
  - GUARD 000
- Transitions:
  - IDLE: reset event→CLR_ARM; else start_stop event→START; lap ignored.
  - START→RUN unconditionally.
  - RUN: reset event→CLR; else start_stop event→STOP; else lap event→capture.
  - STOP→GUARD; CLR_ARM→CLR; CLR→GUARD; GUARD→IDLE, all unconditional.
- Event priority within one cycle: reset > start_stop > lap. Only the winning event acts; the others are dropped.
- Events arriving in START, STOP, CLR_ARM, CLR or GUARD are dropped, not queued.
- Clear from IDLE issues 001 then 011, because the counter only honours 011 while counting.
- GUARD covers the counter's one-cycle STOP_SAVE/STOP_RESET state, so the next start always meets counter IDLE.
- Lap capture (RUN only): `lap_ms` <= `cnt_up_ms` at the edge leaving the event cycle; `lap_valid` is high the following cycle.
- Entering CLR sets `lap_ms` to 0 with no `lap_valid` pulse.
- `running` = (state == RUN).

## Timing
- Reset (`rst` high at an edge):
  - state IDLE, `on_off`=000, `running`=0, `lap_ms`=0, `lap_valid`=0.
  - All synchronizer, debounce and edge flops are 0.
  - Reset mid-sequence (e.g. in STOP) aborts with no further commands; the counter keeps its own state.
- Edge e0 is the rising edge that first samples a button high, with the button held high from then on.
  - Debounced level rises after edge e0+DEBOUNCE_CYCLES+1.
  - Event is high for the following cycle.
  - New state (e.g. START, `on_off`=001) is visible after edge e0+DEBOUNCE_CYCLES+2.
- Any glitch shorter than DEBOUNCE_CYCLES synced cycles produces no event.
- Command pulses are exactly one cycle; `on_off` is 000 in every other cycle.
- Stop: STOP at t+1, GUARD t+2, IDLE t+3. A start event in cycle t+3 is accepted.
- Clear from IDLE: 001 at t+1, 011 at t+2, GUARD t+3, IDLE t+4.
- Clear from RUN: 011 at t+1, GUARD t+2, IDLE t+3.
- Holding a button produces exactly one event; a new press needs a debounced release first.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- **Reset:** assert `rst` for 2 cycles with buttons low → all outputs 0; `on_off` stays 000 for 50 cycles.
- **Start latency:** raise `btn_start_stop` at e0 → `on_off`=001 exactly after edge e0+6 for one cycle, then `running`=1. A 3-cycle glitch on `btn_lap` gives no `lap_valid`.
- **Stop then restart:** stop press in RUN → `on_off` 010 for one cycle, 000, IDLE, `running`=0. A second press → 001. With a behavioral `up_cntr` model (5000 cycles/ms), `cnt_up_ms` resumes from the saved value.
- **Lap:** `cnt_up_ms`=16'd1234 when the lap event fires in RUN → `lap_ms`=1234, `lap_valid` high one cycle. A lap press in IDLE → no change.
- **Clear from IDLE with `lap_ms`=1234:** reset press → `on_off` sequence 001, 011, 000. The counter model reads 0 afterwards; `lap_ms`=0 with no `lap_valid`.
- **Simultaneous events:** reset and start_stop events in the same RUN cycle → 011 issued, 010 never issued. `rst` asserted during CLR_ARM → `on_off`=000 on the next cycle.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: synchronizes and debounces three pushbuttons and sequences
// the one-cycle on_off commands for the millisecond up-counter, plus lap capture.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start_stop,
  input  logic             btn_reset,
  input  logic             btn_lap,
  input  logic [CNT_W-1:0] cnt_up_ms,
  output logic [2:0]       on_off,
  output logic             running,
  output logic [CNT_W-1:0] lap_ms,
  output logic             lap_valid
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] CMD_NONE  = 3'b000;
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_SAVE  = 3'b010;
  localparam logic [2:0] CMD_CLEAR = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_STOP    = 3'd3,
    S_CLR_ARM = 3'd4,
    S_CLR     = 3'd5,
    S_GUARD   = 3'd6
  } state_t;

  logic [2:0]      raw;
  logic [2:0]      sync0;
  logic [2:0]      sync1;
  logic [2:0]      level;
  logic [2:0]      level_q;
  logic [2:0]      ev;
  logic [DB_W-1:0] db_cnt [3];

  state_t     state;
  state_t     state_nxt;
  logic       lap_cap_c;
  logic [2:0] on_off_nxt_c;

  assign raw = {btn_lap, btn_reset, btn_start_stop};

  // Synchronizer, debounce counter and edge flop for each button (bit 0 start/stop, 1 reset, 2 lap)
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0   <= '0;
      sync1   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync0   <= raw;
      sync1   <= sync0;
      level_q <= level;
      for (int i = 0; i < 3; i++) begin
        if (sync1[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press events only; releases are ignored
  assign ev = level & ~level_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state with reset > start_stop > lap priority; events outside IDLE/RUN are dropped
  always_comb begin
    state_nxt    = state;
    lap_cap_c    = 1'b0;
    on_off_nxt_c = CMD_NONE;
    case (state)
      S_IDLE: begin
        if (ev[1])      state_nxt = S_CLR_ARM;
        else if (ev[0]) state_nxt = S_START;
      end
      S_START:   state_nxt = S_RUN;
      S_RUN: begin
        if (ev[1])      state_nxt = S_CLR;
        else if (ev[0]) state_nxt = S_STOP;
        else if (ev[2]) lap_cap_c = 1'b1;
      end
      S_STOP:    state_nxt = S_GUARD;
      S_CLR_ARM: state_nxt = S_CLR;
      S_CLR:     state_nxt = S_GUARD;
      S_GUARD:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_START, S_CLR_ARM: on_off_nxt_c = CMD_START;
      S_STOP:             on_off_nxt_c = CMD_SAVE;
      S_CLR:              on_off_nxt_c = CMD_CLEAR;
      default:            on_off_nxt_c = CMD_NONE;
    endcase
  end

  // Outputs registered from the next-state decode so they track the state register exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      on_off    <= CMD_NONE;
      running   <= 1'b0;
      lap_ms    <= '0;
      lap_valid <= 1'b0;
    end else begin
      on_off    <= on_off_nxt_c;
      running   <= (state_nxt == S_RUN);
      lap_valid <= lap_cap_c;
      if (state_nxt == S_CLR) lap_ms <= '0;
      else if (lap_cap_c)     lap_ms <= cnt_up_ms;
    end
  end

endmodule
